// File: rtl/logic_arb_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter:
// op encodings, FSM state type and counter width.
package logic_arb_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    localparam int CNT_W = 16;

    // IDLE: output register empty. HOLD: output register holds a result.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic unit. Reserved op yields zero with err set.
module logic_op_unit
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    // Evaluate the selected bitwise operation.
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOTA: y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: begin
                y   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a registered logic unit.
// Handshake: a transfer happens in a cycle where valid and ready are both
// high on the same side; valid must not depend on ready, and ready depends
// only on the valids, FSM state, res_ready and the last-grant pointer.
// Optional per-requester grant counters are built when LOGIC_ARB_STATS_EN
// is defined. dbg_state_o exposes the FSM state (0 IDLE, 1 HOLD).
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_err,
`ifdef LOGIC_ARB_STATS_EN
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
`endif
    output logic             dbg_state_o
);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;
    logic             err_q, err_d;

    logic             gnt_idx;
    logic             slot_free;
    logic             xfer;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] op_y;
    logic             op_err;

    // Pick the requester to serve: the only valid one, or the one not
    // granted last when both are valid.
    always_comb begin
        gnt_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_idx = ~last_grant_q;
        end else if (req1_valid) begin
            gnt_idx = 1'b1;
        end
    end

    // Slot is free when empty or being drained this cycle; no ready in reset.
    assign slot_free  = rst_n && ((state_q == ST_IDLE) || res_ready);
    assign req0_ready = slot_free && req0_valid && !gnt_idx;
    assign req1_ready = slot_free && req1_valid &&  gnt_idx;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign sel_op = gnt_idx ? req1_op : req0_op;
    assign sel_a  = gnt_idx ? req1_a  : req0_a;
    assign sel_b  = gnt_idx ? req1_b  : req0_b;

    logic_op_unit #(.WIDTH(WIDTH)) u_op (
        .op  (sel_op),
        .a   (sel_a),
        .b   (sel_b),
        .y   (op_y),
        .err (op_err)
    );

    // Next-state and output-register load: a transfer always lands in HOLD,
    // a drain without transfer returns to IDLE, a stall holds everything.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        id_d         = id_q;
        err_d        = err_q;
        if (xfer) begin
            state_d      = ST_HOLD;
            last_grant_d = gnt_idx;
            data_d       = op_y;
            id_d         = gnt_idx;
            err_d        = op_err;
        end else if (state_q == ST_HOLD && res_ready) begin
            state_d = ST_IDLE;
        end
    end

    // State and result registers; last_grant resets to 1 so req0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            id_q         <= id_d;
            err_q        <= err_d;
        end
    end

    assign res_valid   = (state_q == ST_HOLD);
    assign res_data    = data_q;
    assign res_id      = id_q;
    assign res_err     = err_q;
    assign dbg_state_o = state_q;

`ifdef LOGIC_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Saturating per-requester transfer counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_valid && req0_ready && cnt0_q != 16'hFFFF) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (req1_valid && req1_ready && cnt1_q != 16'hFFFF) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level model (expected-result
// queue, round-robin pointer, op table).
module tb_logic_unit_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id, res_err;
    logic             dbg_state;
`ifdef LOGIC_ARB_STATS_EN
    logic [15:0]      grant_cnt0, grant_cnt1;
`endif

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_err    (res_err),
`ifdef LOGIC_ARB_STATS_EN
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
`endif
        .dbg_state_o(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state: each entry is {id, err, data}
    logic [WIDTH+1:0] exp_q[$];
    logic             last_m;
    int               n_cmp;
    int               n_fail;
    logic [WIDTH-1:0] saved;

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Assert reset, check the cleared outputs immediately, hold, release.
    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
`ifdef LOGIC_ARB_STATS_EN
        chk("rst_cnt0", grant_cnt0, 0);
        chk("rst_cnt1", grant_cnt1, 0);
`endif
        exp_q.delete();
        last_m = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle of traffic: drive, check readies, advance model, check result.
    task automatic step(input logic v0, input logic [2:0] o0,
                        input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                        input logic v1, input logic [2:0] o1,
                        input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                        input logic rr);
        logic free, g, e0, e1;
        logic [WIDTH+1:0] ent;
        @(negedge clk);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
        #1;
        free = (exp_q.size() == 0) || rr;
        g    = (v0 && v1) ? ~last_m : v1;
        e0   = free && v0 && !g;
        e1   = free && v1 && g;
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
        if (e0 || e1) begin
            if (g) exp_q.push_back({1'b1, o1 == 3'd7, ref_op(o1, a1, b1)});
            else   exp_q.push_back({1'b0, o0 == 3'd7, ref_op(o0, a0, b0)});
            last_m = g;
        end
        @(posedge clk);
        #1;
        chk("res_valid", res_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            ent = exp_q[0];
            chk("res_data", res_data, ent[WIDTH-1:0]);
            chk("res_err", res_err, ent[WIDTH]);
            chk("res_id", res_id, ent[WIDTH+1]);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        last_m = 1'b1;
        rst_n  = 1'b0;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = '0; req1_b = '0;
        res_ready  = 1'b0;
        do_reset();

        // req0 alone, AND
        step(1, 3'd0, 8'hF0, 8'h3C, 0, 3'd0, 8'h00, 8'h00, 1);
        chk("and_valid", res_valid, 1);
        chk("and_data", res_data, 8'h30);
        chk("and_id", res_id, 0);
        chk("and_err", res_err, 0);
        step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
        chk("drain_idle", res_valid, 0);

        // Round-robin alternation from reset at full throughput
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 3'd5, 8'h0F, 8'hFF, 1, 3'd1, 8'h11, 8'h22, 1);
            chk("rr_alt_id", res_id, i % 2);
            chk("rr_alt_valid", res_valid, 1);
        end

        // Stall for three cycles with both valid
        step(1, 3'd3, 8'hC3, 8'h81, 1, 3'd4, 8'h12, 8'h34, 1);
        saved = res_data;
        for (int i = 0; i < 3; i++) begin
            step(1, 3'd6, 8'h55, 8'hAA, 1, 3'd0, 8'h77, 8'h88, 0);
            chk("stall_stable", res_data, saved);
        end
        step(1, 3'd6, 8'h55, 8'hAA, 1, 3'd0, 8'h77, 8'h88, 1);
        step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
        step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);

        // Reserved op and NOT a
        step(0, 3'd0, 8'h00, 8'h00, 1, 3'd7, 8'hFF, 8'hFF, 1);
        chk("rsvd_data", res_data, 0);
        chk("rsvd_err", res_err, 1);
        step(1, 3'd2, 8'hA5, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
        chk("nota_data", res_data, 8'h5A);
        chk("nota_err", res_err, 0);

        // Reset while holding: valid drops at once, req0 wins next
        step(0, 3'd0, 8'h00, 8'h00, 1, 3'd1, 8'h0C, 8'h30, 0);
        chk("pre_rst_hold", res_valid, 1);
        do_reset();
        step(1, 3'd1, 8'h01, 8'h02, 1, 3'd1, 8'h04, 8'h08, 1);
        chk("post_rst_id", res_id, 0);
        chk("post_rst_data", res_data, 8'h03);

`ifdef LOGIC_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'hFF, 8'h0F, 1);
        end
        step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
        chk("cnt1_five", grant_cnt1, 5);
        chk("cnt0_zero", grant_cnt0, 0);
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have ports reqN_valid (input, 1 bit) and reqN_ready (output, 1 bit) for N=0,1: the per-requester handshake.
REQ-005 SHALL have port reqN_op, input, 3 bits: the operation select.
REQ-006 SHALL have ports reqN_a and reqN_b, input, WIDTH bits each: the operands.
REQ-007 SHALL have ports res_valid (output, 1 bit) and res_ready (input, 1 bit): the result handshake.
REQ-008 SHALL have port res_data, output, WIDTH bits: the result.
REQ-009 SHALL have port res_id, output, 1 bit: the index of the requester that produced the result.
REQ-010 SHALL have port res_err, output, 1 bit: set when the result came from a reserved op.
REQ-011 SHALL, when LOGIC_ARB_STATS_EN is defined, also have ports grant_cnt0 and grant_cnt1, output, 16 bits each.

Function
REQ-012 SHALL encode ops as 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved; all ops are bitwise over WIDTH bits.
REQ-013 SHALL produce res_data=0 and res_err=1 for op 7.
REQ-014 SHALL implement a two-state FSM with states IDLE (output register empty) and HOLD (res_valid=1).
REQ-015 SHALL treat a slot as free when the FSM is in IDLE, or in HOLD with res_ready=1.
REQ-016 SHALL, when a slot is free, assert reqN_ready only for the single granted requester; a transfer occurs when reqN_valid and reqN_ready are both high.
REQ-017 SHALL grant the only valid requester when exactly one requester is valid.
REQ-018 SHALL, when both requesters are valid, grant the requester not granted most recently (round-robin, last_grant pointer).
REQ-019 SHALL register the result one cycle after the transfer: res_valid, res_data, res_id and res_err all update together.
REQ-020 SHALL hold res_data, res_id and res_err stable while res_valid=1 and res_ready=0.
REQ-021 SHALL, in HOLD, on res_ready=1 with a new transfer in the same cycle, stay in HOLD with the new result, giving one result per cycle at full throughput.
REQ-022 SHALL, in HOLD, on res_ready=1 with no transfer, move to IDLE and deassert res_valid.
REQ-023 SHALL keep both reqN_ready low when the slot is not free.
REQ-024 SHALL generate reqN_ready combinationally from the valids, state, res_ready and last_grant, and SHALL NOT depend combinationally on op or operand inputs.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=IDLE, res_valid=0, res_data=0, res_id=0, res_err=0, last_grant=1 and the counters to 0.
REQ-026 SHALL discard any held result when reset asserts mid-operation; no transfer occurs while rst_n=0.
REQ-027 SHALL grant req0 first after reset when both requesters are valid.

Configuration
REQ-028 SHALL, with LOGIC_ARB_STATS_EN defined, increment grant_cnt0 or grant_cnt1 on each transfer from the corresponding requester, saturating at 16'hFFFF.
REQ-029 SHALL, without LOGIC_ARB_STATS_EN, omit the counter ports and the counter logic entirely; all other behaviour is identical.

Structure
REQ-030 SHALL place the op encoding constants (OP_AND..OP_RSVD) and the FSM state typedef in the shared package logic_arb_pkg.
REQ-031 SHALL place the combinational op evaluation in a sub-module logic_op_unit (inputs op, a, b; outputs y, err), instantiated exactly once.

Verification
REQ-032 SHALL cover: req0 alone with op=0, a=8'hF0, b=8'h3C -> the cycle after transfer, res_valid=1, res_data=8'h30, res_id=0, res_err=0.
REQ-033 SHALL cover: both requesters valid continuously with res_ready=1 held high -> grants alternate 0,1,0,1 from reset, one result per cycle.
REQ-034 SHALL cover: res_ready=0 for 3 cycles with both requesters valid -> both reqN_ready stay low, res_data stays stable, and nothing is lost.
REQ-035 SHALL cover: op=7 -> res_data=0, res_err=1; op=2, a=8'hA5 -> res_data=8'h5A.
REQ-036 SHALL cover: rst_n pulsed low while in HOLD -> res_valid drops immediately, and the next dual request is granted to req0.
REQ-037 SHALL cover, with LOGIC_ARB_STATS_EN: 5 req1 transfers -> grant_cnt1=5, grant_cnt0=0.
